n101_ncyc_sram_ctrl: RTL and testbench
======================================

Name: n101_ncyc_sram_ctrl

Overview:
- Parametrised SRAM controller for TCM/ITCM/DTCM macros with configurable read latency LAT (1-4 cycles).
- Sits between the uop-side valid/ready command/response channels and a single-port SRAM macro; drives a gated RAM clock.
- Holds multiple commands in flight (one per cycle) and holds returned RAM data in a response buffer, so response backpressure never loses data.
- Behaviour the one-cycle controller lacks: multi-cycle latency and outstanding-request credit tracking.

Parameters:
- DW, 32, data width
- MW, 4, write-mask width (DW/8)
- AW, 32, command address width
- AW_LSB, 3, address LSBs dropped to form RAM word address
- USR_W, 3, user sideband width
- LAT, 2, RAM read latency in cycles, legal 1..4
- RSP_DP, 3, response credits, legal LAT..8; full throughput needs RSP_DP >= LAT+1
- RAM_WORDS, 1024, legal RAM depth in words (used only by optional feature)

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- sram_ctrl_active  output  1  controller busy
- tcm_cgstop  input  1  force RAM clock enable
- clkgate_bypass  input  1  clock-gate test bypass
- stall_uop_cmd  input  1  block command acceptance
- uop_cmd_valid  input  1  command valid
- uop_cmd_ready  output  1  command ready
- uop_cmd_read  input  1  1=read, 0=write
- uop_cmd_addr  input  AW  byte address
- uop_cmd_wdata  input  DW  write data
- uop_cmd_wmask  input  MW  byte write mask
- uop_cmd_usr  input  USR_W  user tag
- uop_rsp_valid  output  1  response valid
- uop_rsp_ready  input  1  response ready
- uop_rsp_rdata  output  DW  read data (0 for writes)
- uop_rsp_usr  output  USR_W  returned user tag
- uop_rsp_err  output  1  address error (tied 0 without optional feature)
- ram_cs  output  1  RAM chip select
- ram_addr  output  AW-AW_LSB  RAM word address
- ram_wem  output  MW  RAM byte write enables
- ram_din  output  DW  RAM write data
- ram_dout  input  DW  RAM read data
- clk_ram  output  1  gated RAM clock

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low. All state clears on reset; no outstanding response survives reset.
- Credit counter: cnt = in-flight commands + buffered responses, width clog2(RSP_DP+1), reset 0.
- uop_cmd_ready = ~stall_uop_cmd & (cnt < RSP_DP). There is no combinational path from uop_rsp_ready to uop_cmd_ready.
- Accept: acc = uop_cmd_valid & uop_cmd_ready.
- RAM command:
  - ram_cs = acc.
  - ram_addr = uop_cmd_addr[AW-1:AW_LSB].
  - ram_wem = {MW{~uop_cmd_read}} & uop_cmd_wmask.
  - ram_din = uop_cmd_wdata.
- Clock gating: clk_ram is gated by n101_clkgate, enable = ram_cs | tcm_cgstop | (any in-flight stage valid), bypassed when clkgate_bypass=1.
- In-flight pipeline: LAT-stage shift register of {vld, read, usr, err}, stage valids reset 0. An entry enters at acc and exits at stage LAT exactly LAT cycles later.
- Exit data: rdata = read ? ram_dout : 0, sampled in the exit cycle.
- Response FIFO: depth RSP_DP, holds {rdata, usr, err}; pointers wrap modulo RSP_DP; reset empty.
- Response output:
  - FIFO non-empty: output the FIFO head.
  - FIFO empty and entry exiting this cycle: bypass the exiting entry combinationally, so latency is exactly LAT cycles.
  - Exiting entry is written into the FIFO unless it is bypassed and uop_rsp_ready=1.
- Ordering: responses return strictly in command order.
- Counter update: cnt increments on acc and decrements on uop_rsp_valid & uop_rsp_ready; a simultaneous increment and decrement leaves cnt unchanged. cnt never exceeds RSP_DP, so the FIFO never overflows.
- Activity: sram_ctrl_active = uop_cmd_valid | (cnt != 0).
- Output reset values: uop_rsp_valid=0, uop_cmd_ready=~stall_uop_cmd, ram_cs=0, uop_rsp_err=0.
- stall_uop_cmd held high: no new commands are accepted; in-flight commands still complete and respond.

Optional Feature:
- Macro: N101_SRAM_CTRL_ADDR_CHK_EN.
- Defined:
  - A command whose word address >= RAM_WORDS is accepted but not issued to the RAM (ram_cs=0 for it).
  - It still traverses the LAT pipeline, keeping response order.
  - Its response has uop_rsp_err=1 and rdata=0.
- Undefined: uop_rsp_err tied 0; every accepted command is issued to the RAM.

Test Plan:
- Back-to-back reads, LAT=2, RSP_DP=3, rsp_ready=1, addr 0x0/0x8/0x10 holding A/B/C -> responses A, B, C in cycles 2, 3, 4 after the first acc; cmd_ready stays 1.
- Write with wmask 4'b0101, data 0x11223344 to addr 0x20, then read it back (RAM preset 0) -> ram_wem=0101; read returns 0x00220044; write response rdata=0.
- rsp_ready held 0 while 5 reads are offered -> exactly 3 accepted, cmd_ready=0 from then on; releasing rsp_ready drains 3 responses in order with usr tags intact.
- stall_uop_cmd=1 mid-stream with 2 in flight -> no new acc; both responses still delivered; sram_ctrl_active falls to 0 after the drain.
- rst_n asserted with 2 commands in flight and 1 buffered -> uop_rsp_valid=0 immediately; cnt=0 after release; next read returns with latency LAT.
- With N101_SRAM_CTRL_ADDR_CHK_EN, RAM_WORDS=1024, read addr 0x2000 -> ram_cs=0; response err=1, rdata=0, returned in order behind a preceding legal read.

Source files
------------

// File: rtl/n101_ncyc_sram_ctrl_if.sv
// rtl/n101_ncyc_sram_ctrl_if.sv - uop command/response channel bundle for the n-cycle SRAM controller
//
// Purpose: groups the uop-side valid/ready command and response channels.
// Signals:
//   uop_cmd_valid/ready      command handshake
//   uop_cmd_read             1=read, 0=write
//   uop_cmd_addr  [AW]       byte address
//   uop_cmd_wdata [DW]       write data
//   uop_cmd_wmask [MW]       byte write mask
//   uop_cmd_usr   [USR_W]    user tag carried to the response
//   uop_rsp_valid/ready      response handshake
//   uop_rsp_rdata [DW]       read data (0 for writes)
//   uop_rsp_usr   [USR_W]    returned user tag
//   uop_rsp_err              address error
// Modports: master = uop side, slave = controller.
interface n101_ncyc_sram_ctrl_if #(
  parameter int DW    = 32,
  parameter int MW    = 4,
  parameter int AW    = 32,
  parameter int USR_W = 3
);
  logic             uop_cmd_valid;
  logic             uop_cmd_ready;
  logic             uop_cmd_read;
  logic [AW-1:0]    uop_cmd_addr;
  logic [DW-1:0]    uop_cmd_wdata;
  logic [MW-1:0]    uop_cmd_wmask;
  logic [USR_W-1:0] uop_cmd_usr;
  logic             uop_rsp_valid;
  logic             uop_rsp_ready;
  logic [DW-1:0]    uop_rsp_rdata;
  logic [USR_W-1:0] uop_rsp_usr;
  logic             uop_rsp_err;

  modport master (
    output uop_cmd_valid, uop_cmd_read, uop_cmd_addr, uop_cmd_wdata,
           uop_cmd_wmask, uop_cmd_usr, uop_rsp_ready,
    input  uop_cmd_ready, uop_rsp_valid, uop_rsp_rdata, uop_rsp_usr, uop_rsp_err
  );

  modport slave (
    input  uop_cmd_valid, uop_cmd_read, uop_cmd_addr, uop_cmd_wdata,
           uop_cmd_wmask, uop_cmd_usr, uop_rsp_ready,
    output uop_cmd_ready, uop_rsp_valid, uop_rsp_rdata, uop_rsp_usr, uop_rsp_err
  );
endinterface

// File: rtl/n101_ncyc_sram_ctrl.sv
// rtl/n101_ncyc_sram_ctrl.sv - multi-cycle-latency SRAM controller with response credit tracking
//
// Purpose: issues uop commands to a single-port SRAM with read latency LAT,
// tracks in-flight commands through a LAT-stage pipeline and buffers returned
// data in an RSP_DP-deep response FIFO so response backpressure never loses data.
// Optional feature macro: N101_SRAM_CTRL_ADDR_CHK_EN (word address range check
// against RAM_WORDS; out-of-range commands are not issued and respond with err=1).
// Ports:
//   clk, rst_n             core clock, asynchronous active-low reset
//   uop                    command/response channels (slave modport)
//   i_tcm_cgstop           force RAM clock enable
//   i_clkgate_bypass       clock-gate test bypass
//   i_stall_uop_cmd        block command acceptance
//   o_sram_ctrl_active     controller busy
//   o_ram_cs/addr/wem/din  RAM command
//   i_ram_dout             RAM read data, valid LAT cycles after ram_cs
//   o_clk_ram              gated RAM clock

// Latch-based clock gate: enable is captured while clk is low so the gated
// clock never glitches during the high phase.
module n101_clkgate (
  input  logic i_clk,
  input  logic i_en,
  input  logic i_bypass,
  output logic o_gclk
);
  logic r_en_lat;

  always_latch begin
    if (!i_clk) r_en_lat <= i_en | i_bypass;
  end

  assign o_gclk = i_clk & r_en_lat;
endmodule

module n101_ncyc_sram_ctrl #(
  parameter int DW        = 32,
  parameter int MW        = 4,
  parameter int AW        = 32,
  parameter int AW_LSB    = 3,
  parameter int USR_W     = 3,
  parameter int LAT       = 2,
  parameter int RSP_DP    = 3,
  parameter int RAM_WORDS = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  n101_ncyc_sram_ctrl_if.slave uop,
  input  logic                 i_tcm_cgstop,
  input  logic                 i_clkgate_bypass,
  input  logic                 i_stall_uop_cmd,
  output logic                 o_sram_ctrl_active,
  output logic                 o_ram_cs,
  output logic [AW-AW_LSB-1:0] o_ram_addr,
  output logic [MW-1:0]        o_ram_wem,
  output logic [DW-1:0]        o_ram_din,
  input  logic [DW-1:0]        i_ram_dout,
  output logic                 o_clk_ram
);
  localparam int RAW = AW - AW_LSB;
  localparam int CW  = $clog2(RSP_DP + 1);
  localparam int PW  = (RSP_DP > 1) ? $clog2(RSP_DP) : 1;
  localparam logic [CW-1:0]  CNT_MAX    = CW'(RSP_DP);
  localparam logic [PW-1:0]  PTR_LAST   = PW'(RSP_DP - 1);
  localparam logic [RAW-1:0] WORD_LIMIT = RAW'(RAM_WORDS);

  // ---------------------------------------------------------------------------
  // Command acceptance and credits
  // ---------------------------------------------------------------------------
  logic [CW-1:0]  r_cnt;
  logic           w_cmd_ready;
  logic           w_acc;
  logic [RAW-1:0] w_word_addr;
  logic           w_addr_oor;
  logic           w_addr_err;
  logic           w_unused;

  assign w_word_addr = uop.uop_cmd_addr[AW-1:AW_LSB];
  assign w_addr_oor  = (w_word_addr >= WORD_LIMIT);

`ifdef N101_SRAM_CTRL_ADDR_CHK_EN
  assign w_addr_err = w_addr_oor;
  assign w_unused   = &{1'b0, uop.uop_cmd_addr[AW_LSB-1:0]};
`else
  assign w_addr_err = 1'b0;
  assign w_unused   = &{1'b0, uop.uop_cmd_addr[AW_LSB-1:0], w_addr_oor};
`endif

  // Credits depend only on registered count, never on uop_rsp_ready.
  assign w_cmd_ready       = ~i_stall_uop_cmd & (r_cnt < CNT_MAX);
  assign uop.uop_cmd_ready = w_cmd_ready;
  assign w_acc             = uop.uop_cmd_valid & w_cmd_ready;

  // ---------------------------------------------------------------------------
  // RAM command
  // ---------------------------------------------------------------------------
  assign o_ram_cs   = w_acc & ~w_addr_err;
  assign o_ram_addr = w_word_addr;
  assign o_ram_wem  = {MW{~uop.uop_cmd_read}} & uop.uop_cmd_wmask;
  assign o_ram_din  = uop.uop_cmd_wdata;

  // ---------------------------------------------------------------------------
  // In-flight pipeline: stage k holds the command accepted k cycles ago
  // ---------------------------------------------------------------------------
  logic [LAT:1]     r_vld;
  logic [LAT:1]     r_rd;
  logic [LAT:1]     r_err;
  logic [USR_W-1:0] r_usr [1:LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_rd  <= '0;
      r_err <= '0;
      for (int i = 1; i <= LAT; i++) r_usr[i] <= '0;
    end else begin
      r_vld[1] <= w_acc;
      r_rd[1]  <= uop.uop_cmd_read;
      r_err[1] <= w_addr_err;
      r_usr[1] <= uop.uop_cmd_usr;
      for (int i = 2; i <= LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_rd[i]  <= r_rd[i-1];
        r_err[i] <= r_err[i-1];
        r_usr[i] <= r_usr[i-1];
      end
    end
  end

  logic             w_exit_vld;
  logic [DW-1:0]    w_exit_rdata;
  logic [USR_W-1:0] w_exit_usr;
  logic             w_exit_err;

  // Writes and rejected commands return zero data; the RAM is only sampled
  // for a legal read in its exit cycle.
  assign w_exit_vld   = r_vld[LAT];
  assign w_exit_rdata = (r_rd[LAT] & ~r_err[LAT]) ? i_ram_dout : '0;
  assign w_exit_usr   = r_usr[LAT];
  assign w_exit_err   = r_err[LAT];

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  logic [DW-1:0]     r_fifo_rdata [RSP_DP];
  logic [USR_W-1:0]  r_fifo_usr   [RSP_DP];
  logic [RSP_DP-1:0] r_fifo_err;
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_fcnt;
  logic              w_fifo_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_rsp_valid;
  logic              w_rsp_fire;

  assign w_fifo_empty = (r_fcnt == '0);
  assign w_rsp_valid  = ~w_fifo_empty | w_exit_vld;
  assign w_rsp_fire   = w_rsp_valid & uop.uop_rsp_ready;
  // The exiting entry skips the FIFO only when it is bypassed and taken now.
  assign w_push       = w_exit_vld & ~(w_fifo_empty & uop.uop_rsp_ready);
  assign w_pop        = ~w_fifo_empty & uop.uop_rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_fcnt     <= '0;
      r_fifo_err <= '0;
      for (int i = 0; i < RSP_DP; i++) begin
        r_fifo_rdata[i] <= '0;
        r_fifo_usr[i]   <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo_rdata[r_wptr] <= w_exit_rdata;
        r_fifo_usr[r_wptr]   <= w_exit_usr;
        r_fifo_err[r_wptr]   <= w_exit_err;
        r_wptr               <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  // Response output: FIFO head has priority, otherwise bypass the exiting entry.
  always_comb begin
    uop.uop_rsp_valid = w_rsp_valid;
    uop.uop_rsp_rdata = w_exit_rdata;
    uop.uop_rsp_usr   = w_exit_usr;
    uop.uop_rsp_err   = w_exit_vld & w_exit_err;
    if (!w_fifo_empty) begin
      uop.uop_rsp_rdata = r_fifo_rdata[r_rptr];
      uop.uop_rsp_usr   = r_fifo_usr[r_rptr];
      uop.uop_rsp_err   = r_fifo_err[r_rptr];
    end
  end

  // ---------------------------------------------------------------------------
  // Credit counter: in-flight commands plus buffered responses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      case ({w_acc, w_rsp_fire})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_sram_ctrl_active = uop.uop_cmd_valid | (r_cnt != '0);

  // ---------------------------------------------------------------------------
  // RAM clock gating: run while issuing or while any read is still in flight
  // ---------------------------------------------------------------------------
  logic w_ram_clk_en;

  assign w_ram_clk_en = o_ram_cs | i_tcm_cgstop | (|r_vld);

  n101_clkgate u_clkgate (
    .i_clk    (clk),
    .i_en     (w_ram_clk_en),
    .i_bypass (i_clkgate_bypass),
    .o_gclk   (o_clk_ram)
  );
endmodule

// File: tb/tb_n101_ncyc_sram_ctrl.sv
// tb/tb_n101_ncyc_sram_ctrl.sv - directed self-checking bench for n101_ncyc_sram_ctrl
module tb_n101_ncyc_sram_ctrl;
  localparam int DW = 32, MW = 4, AW = 32, AW_LSB = 3, USR_W = 3;
  localparam int LAT = 2, RSP_DP = 3, RAM_WORDS = 1024;

  localparam logic [31:0] DA = 32'hAAAA_0001;
  localparam logic [31:0] DB = 32'hBBBB_0002;
  localparam logic [31:0] DC = 32'hCCCC_0003;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tcm_cgstop = 1'b0;
  logic clkgate_bypass = 1'b0;
  logic stall_uop_cmd = 1'b0;
  logic sram_ctrl_active;
  logic ram_cs;
  logic [AW-AW_LSB-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic clk_ram;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  n101_ncyc_sram_ctrl_if #(.DW(DW), .MW(MW), .AW(AW), .USR_W(USR_W)) u_if ();

  n101_ncyc_sram_ctrl #(
    .DW(DW), .MW(MW), .AW(AW), .AW_LSB(AW_LSB), .USR_W(USR_W),
    .LAT(LAT), .RSP_DP(RSP_DP), .RAM_WORDS(RAM_WORDS)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .uop                (u_if),
    .i_tcm_cgstop       (tcm_cgstop),
    .i_clkgate_bypass   (clkgate_bypass),
    .i_stall_uop_cmd    (stall_uop_cmd),
    .o_sram_ctrl_active (sram_ctrl_active),
    .o_ram_cs           (ram_cs),
    .o_ram_addr         (ram_addr),
    .o_ram_wem          (ram_wem),
    .o_ram_din          (ram_din),
    .i_ram_dout         (ram_dout),
    .o_clk_ram          (clk_ram)
  );

  // Behavioural SRAM: LAT-cycle read latency, byte write enables.
  logic [DW-1:0] mem [64];
  logic [DW-1:0] rd_pipe [LAT];

  always @(posedge clk) begin
    if (ram_cs) begin
      for (int b = 0; b < MW; b++)
        if (ram_wem[b]) mem[ram_addr[5:0]][b*8 +: 8] <= ram_din[b*8 +: 8];
      rd_pipe[0] <= mem[ram_addr[5:0]];
    end
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_dout = rd_pipe[LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic cmd(input logic v, input logic rd, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] wm, input logic [2:0] usr);
    u_if.uop_cmd_valid = v;
    u_if.uop_cmd_read  = rd;
    u_if.uop_cmd_addr  = a;
    u_if.uop_cmd_wdata = wd;
    u_if.uop_cmd_wmask = wm;
    u_if.uop_cmd_usr   = usr;
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] d, input logic [2:0] usr, input logic err);
    check({tag, ".valid"}, 64'(u_if.uop_rsp_valid), 64'd1);
    check({tag, ".rdata"}, 64'(u_if.uop_rsp_rdata), 64'(d));
    check({tag, ".usr"},   64'(u_if.uop_rsp_usr),   64'(usr));
    check({tag, ".err"},   64'(u_if.uop_rsp_err),   64'(err));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
    mem[0] = DA;
    mem[1] = DB;
    mem[2] = DC;
    cmd(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 3'd0);
    u_if.uop_rsp_ready = 1'b1;

    // Reset state
    tick();
    settle();
    check("rst.rsp_valid", 64'(u_if.uop_rsp_valid), 64'd0);
    check("rst.cmd_ready", 64'(u_if.uop_cmd_ready), 64'd1);
    check("rst.ram_cs",    64'(ram_cs),              64'd0);
    check("rst.rsp_err",   64'(u_if.uop_rsp_err),   64'd0);
    check("rst.active",    64'(sram_ctrl_active),    64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Clock gating
    settle();
    check("cg.idle", 64'(clk_ram), 64'd0);
    tcm_cgstop = 1'b1;
    tick();
    settle();
    check("cg.cgstop", 64'(clk_ram), 64'd1);
    tcm_cgstop = 1'b0;
    tick();
    settle();
    check("cg.off", 64'(clk_ram), 64'd0);
    clkgate_bypass = 1'b1;
    tick();
    settle();
    check("cg.bypass", 64'(clk_ram), 64'd1);
    clkgate_bypass = 1'b0;
    tick();

    // Back-to-back reads, responses LAT cycles later
    cmd(1'b1, 1'b1, 32'h00, 32'h0, 4'h0, 3'd1);
    settle();
    check("b2b.c0.ready", 64'(u_if.uop_cmd_ready), 64'd1);
    check("b2b.c0.cs",    64'(ram_cs),              64'd1);
    check("b2b.c0.addr",  64'(ram_addr),            64'd0);
    check("b2b.c0.rspv",  64'(u_if.uop_rsp_valid), 64'd0);
    tick();
    cmd(1'b1, 1'b1, 32'h08, 32'h0, 4'h0, 3'd2);
    settle();
    check("b2b.c1.ready", 64'(u_if.uop_cmd_ready), 64'd1);
    check("b2b.c1.addr",  64'(ram_addr),            64'd1);
    check("b2b.c1.rspv",  64'(u_if.uop_rsp_valid), 64'd0);
    check("b2b.c1.clk_ram", 64'(clk_ram),           64'd1);
    tick();
    cmd(1'b1, 1'b1, 32'h10, 32'h0, 4'h0, 3'd3);
    settle();
    check("b2b.c2.ready", 64'(u_if.uop_cmd_ready), 64'd1);
    chk_rsp("b2b.A", DA, 3'd1, 1'b0);
    tick();
    cmd(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 3'd0);
    settle();
    chk_rsp("b2b.B", DB, 3'd2, 1'b0);
    tick();
    settle();
    chk_rsp("b2b.C", DC, 3'd3, 1'b0);
    tick();
    settle();
    check("b2b.done.rspv",   64'(u_if.uop_rsp_valid), 64'd0);
    check("b2b.done.active", 64'(sram_ctrl_active),    64'd0);

    // Masked write then read back
    cmd(1'b1, 1'b0, 32'h20, 32'h1122_3344, 4'b0101, 3'd4);
    settle();
    check("wr.cs",   64'(ram_cs),   64'd1);
    check("wr.wem",  64'(ram_wem),  64'b0101);
    check("wr.addr", 64'(ram_addr), 64'd4);
    check("wr.din",  64'(ram_din),  64'h1122_3344);
    tick();
    cmd(1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 3'd5);
    settle();
    check("rd.wem", 64'(ram_wem), 64'd0);
    tick();
    cmd(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 3'd0);
    settle();
    chk_rsp("wr.rsp", 32'h0, 3'd4, 1'b0);
    tick();
    settle();
    chk_rsp("rd.rsp", 32'h0022_0044, 3'd5, 1'b0);
    tick();

    // Backpressure: 5 reads offered with rsp_ready low, 3 credits
    u_if.uop_rsp_ready = 1'b0;
    cmd(1'b1, 1'b1, 32'h00, 32'h0, 4'h0, 3'd5);
    settle();
    check("bp.d0.cs", 64'(ram_cs), 64'd1);
    tick();
    cmd(1'b1, 1'b1, 32'h08, 32'h0, 4'h0, 3'd6);
    settle();
    check("bp.d1.cs", 64'(ram_cs), 64'd1);
    tick();
    cmd(1'b1, 1'b1, 32'h10, 32'h0, 4'h0, 3'd7);
    settle();
    check("bp.d2.cs", 64'(ram_cs), 64'd1);
    tick();
    cmd(1'b1, 1'b1, 32'h18, 32'h0, 4'h0, 3'd0);
    settle();
    check("bp.d3.ready", 64'(u_if.uop_cmd_ready), 64'd0);
    check("bp.d3.cs",    64'(ram_cs),              64'd0);
    check("bp.d3.rspv",  64'(u_if.uop_rsp_valid), 64'd1);
    tick();
    settle();
    check("bp.d4.ready", 64'(u_if.uop_cmd_ready), 64'd0);
    check("bp.d4.cs",    64'(ram_cs),              64'd0);
    tick();
    cmd(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 3'd0);
    settle();
    check("bp.d5.ready", 64'(u_if.uop_cmd_ready), 64'd0);
    tick();
    u_if.uop_rsp_ready = 1'b1;
    settle();
    chk_rsp("bp.A", DA, 3'd5, 1'b0);
    tick();
    settle();
    chk_rsp("bp.B", DB, 3'd6, 1'b0);
    tick();
    settle();
    chk_rsp("bp.C", DC, 3'd7, 1'b0);
    tick();
    settle();
    check("bp.drained.rspv",  64'(u_if.uop_rsp_valid), 64'd0);
    check("bp.drained.ready", 64'(u_if.uop_cmd_ready), 64'd1);

    // Stall with two commands in flight
    cmd(1'b1, 1'b1, 32'h00, 32'h0, 4'h0, 3'd1);
    tick();
    cmd(1'b1, 1'b1, 32'h08, 32'h0, 4'h0, 3'd2);
    tick();
    stall_uop_cmd = 1'b1;
    cmd(1'b1, 1'b1, 32'h10, 32'h0, 4'h0, 3'd3);
    settle();
    check("st.e2.ready",  64'(u_if.uop_cmd_ready), 64'd0);
    check("st.e2.cs",     64'(ram_cs),              64'd0);
    check("st.e2.active", 64'(sram_ctrl_active),    64'd1);
    chk_rsp("st.A", DA, 3'd1, 1'b0);
    tick();
    settle();
    check("st.e3.cs", 64'(ram_cs), 64'd0);
    chk_rsp("st.B", DB, 3'd2, 1'b0);
    tick();
    cmd(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 3'd0);
    settle();
    check("st.e4.rspv",   64'(u_if.uop_rsp_valid), 64'd0);
    check("st.e4.active", 64'(sram_ctrl_active),    64'd0);
    tick();
    stall_uop_cmd = 1'b0;

    // Reset with two in flight and one buffered
    u_if.uop_rsp_ready = 1'b0;
    cmd(1'b1, 1'b1, 32'h00, 32'h0, 4'h0, 3'd1);
    tick();
    cmd(1'b1, 1'b1, 32'h08, 32'h0, 4'h0, 3'd2);
    tick();
    cmd(1'b1, 1'b1, 32'h10, 32'h0, 4'h0, 3'd3);
    tick();
    cmd(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 3'd0);
    settle();
    check("rr.pre.rspv",  64'(u_if.uop_rsp_valid), 64'd1);
    check("rr.pre.ready", 64'(u_if.uop_cmd_ready), 64'd0);
    rst_n = 1'b0;
    settle();
    check("rr.rspv",   64'(u_if.uop_rsp_valid), 64'd0);
    check("rr.ready",  64'(u_if.uop_cmd_ready), 64'd1);
    check("rr.active", 64'(sram_ctrl_active),    64'd0);
    tick();
    rst_n = 1'b1;
    u_if.uop_rsp_ready = 1'b1;
    tick();
    cmd(1'b1, 1'b1, 32'h10, 32'h0, 4'h0, 3'd6);
    tick();
    cmd(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 3'd0);
    settle();
    check("rr.g1.rspv", 64'(u_if.uop_rsp_valid), 64'd0);
    tick();
    settle();
    chk_rsp("rr.C", DC, 3'd6, 1'b0);
    tick();
    settle();
    check("rr.g3.rspv",   64'(u_if.uop_rsp_valid), 64'd0);
    check("rr.g3.active", 64'(sram_ctrl_active),    64'd0);

`ifdef N101_SRAM_CTRL_ADDR_CHK_EN
    // Out-of-range read behind a legal read
    cmd(1'b1, 1'b1, 32'h0, 32'h0, 4'h0, 3'd1);
    tick();
    cmd(1'b1, 1'b1, 32'h2000, 32'h0, 4'h0, 3'd2);
    settle();
    check("ac.ready", 64'(u_if.uop_cmd_ready), 64'd1);
    check("ac.cs",    64'(ram_cs),              64'd0);
    tick();
    cmd(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 3'd0);
    settle();
    chk_rsp("ac.legal", DA, 3'd1, 1'b0);
    tick();
    settle();
    chk_rsp("ac.oor", 32'h0, 3'd2, 1'b1);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
